// File: rtl/iobuf_turnaround_ctrl.sv
// Turnaround sequencer for one bank of tristate pad buffers shared by a write and a read requester.
// Optional bus parking after writes is enabled by defining IOBUF_PARK_DRIVE_EN.
module iobuf_turnaround_ctrl #(
  parameter int WIDTH       = 8,
  parameter int TURN_CYCLES = 2,
  parameter int RD_LAT      = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             WR_VALID,
  input  logic [WIDTH-1:0] WR_DATA,
  output logic             WR_READY,
  input  logic             RD_VALID,
  output logic             RD_READY,
  output logic [WIDTH-1:0] RD_DATA,
  output logic             RD_DONE,
  output logic [WIDTH-1:0] PAD_I,
  output logic             PAD_T,
  input  logic [WIDTH-1:0] PAD_O,
  output logic             BUSY
);

  localparam int MAX_CNT = (TURN_CYCLES > RD_LAT) ? TURN_CYCLES : RD_LAT;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam logic [CW-1:0] TURN_LD = CW'(TURN_CYCLES);
  localparam logic [CW-1:0] RD_LD   = CW'(RD_LAT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

`ifdef IOBUF_PARK_DRIVE_EN
  localparam bit PARK_EN = 1'b1;
`else
  localparam bit PARK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRV      = 2'd1,
    SMP_WAIT = 2'd2,
    TURN     = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_rd_q, last_rd_d;
  logic             rd_pend_q, rd_pend_d;
  logic             pad_t_q, pad_t_d;
  logic [WIDTH-1:0] pad_i_q, pad_i_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_done_q, rd_done_d;
  logic             wr_ready, rd_ready;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_rd_d = last_rd_q;
    rd_pend_d = rd_pend_q;
    pad_t_d   = pad_t_q;
    pad_i_d   = pad_i_q;
    rd_data_d = rd_data_q;
    rd_done_d = 1'b0;
    wr_ready  = 1'b0;
    rd_ready  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Round-robin: a contested write wins only if the read went last.
        if (WR_VALID && (!RD_VALID || last_rd_q)) begin
          wr_ready  = 1'b1;
          last_rd_d = 1'b0;
          pad_i_d   = WR_DATA;
          pad_t_d   = 1'b0;
          state_d   = DRV;
        end else if (RD_VALID) begin
          rd_ready  = 1'b1;
          last_rd_d = 1'b1;
          pad_t_d   = 1'b1;
          // Bus only driven in IDLE when parked: release it before sampling.
          if (PARK_EN && !pad_t_q && TURN_CYCLES != 0) begin
            rd_pend_d = 1'b1;
            cnt_d     = TURN_LD;
            state_d   = TURN;
          end else begin
            cnt_d   = RD_LD;
            state_d = SMP_WAIT;
          end
        end
      end

      DRV: begin
        if (WR_VALID && !RD_VALID) begin
          wr_ready = 1'b1;
          pad_i_d  = WR_DATA;
        end else if (PARK_EN) begin
          state_d = IDLE;
        end else begin
          pad_t_d = 1'b1;
          cnt_d   = TURN_LD;
          state_d = (TURN_CYCLES == 0) ? IDLE : TURN;
        end
      end

      SMP_WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          rd_data_d = PAD_O;
          rd_done_d = 1'b1;
          cnt_d     = TURN_LD;
          state_d   = (TURN_CYCLES == 0) ? IDLE : TURN;
        end
      end

      TURN: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q <= CNT_ONE) begin
          if (rd_pend_q) begin
            rd_pend_d = 1'b0;
            cnt_d     = RD_LD;
            state_d   = SMP_WAIT;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_rd_q <= 1'b1;
      rd_pend_q <= 1'b0;
      pad_t_q   <= 1'b1;
      pad_i_q   <= '0;
      rd_data_q <= '0;
      rd_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_rd_q <= last_rd_d;
      rd_pend_q <= rd_pend_d;
      pad_t_q   <= pad_t_d;
      pad_i_q   <= pad_i_d;
      rd_data_q <= rd_data_d;
      rd_done_q <= rd_done_d;
    end
  end

  assign WR_READY = wr_ready;
  assign RD_READY = rd_ready;
  assign RD_DATA  = rd_data_q;
  assign RD_DONE  = rd_done_q;
  assign PAD_I    = pad_i_q;
  assign PAD_T    = pad_t_q;
  assign BUSY     = (state_q != IDLE);

endmodule

// File: tb/tb_iobuf_turnaround_ctrl.sv
// Directed bench for iobuf_turnaround_ctrl with default parameters (WIDTH=8, TURN_CYCLES=2, RD_LAT=1).
// Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
module tb_iobuf_turnaround_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       WR_VALID, RD_VALID;
  logic [7:0] WR_DATA, PAD_O;
  logic       WR_READY, RD_READY, RD_DONE, PAD_T, BUSY;
  logic [7:0] RD_DATA, PAD_I;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  iobuf_turnaround_ctrl #(.WIDTH(8), .TURN_CYCLES(2), .RD_LAT(1)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .WR_VALID(WR_VALID), .WR_DATA(WR_DATA), .WR_READY(WR_READY),
    .RD_VALID(RD_VALID), .RD_READY(RD_READY),
    .RD_DATA(RD_DATA), .RD_DONE(RD_DONE),
    .PAD_I(PAD_I), .PAD_T(PAD_T), .PAD_O(PAD_O), .BUSY(BUSY)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic mid();
    @(negedge CLK);
  endtask

  initial begin
    logic [12:0] exp_wr;
    logic [12:0] exp_rd;
    logic [12:0] exp_pt;

    RST_N = 1'b0; WR_VALID = 1'b0; RD_VALID = 1'b0; WR_DATA = '0; PAD_O = '0;
    mid();
    check("rst_pad_t",   PAD_T,    1);
    check("rst_pad_i",   PAD_I,    0);
    check("rst_rd_data", RD_DATA,  0);
    check("rst_rd_done", RD_DONE,  0);
    check("rst_busy",    BUSY,     0);
    check("rst_wr_rdy",  WR_READY, 0);
    next_cycle();
    RST_N = 1'b1;

    // Read: accept c0, sample end of c1, RD_DONE in c2, TURN c2-c3, IDLE c4.
    PAD_O = 8'h3C; RD_VALID = 1'b1;
    mid();
    check("rd_ready",    RD_READY, 1);
    check("rd_wr_ready", WR_READY, 0);
    next_cycle(); RD_VALID = 1'b0;
    mid();
    check("rd_c1_pad_t", PAD_T,   1);
    check("rd_c1_done",  RD_DONE, 0);
    next_cycle();
    mid();
    check("rd_c2_done",  RD_DONE, 1);
    check("rd_c2_data",  RD_DATA, 8'h3C);
    check("rd_c2_pad_t", PAD_T,   1);
    PAD_O = 8'h00;
    next_cycle();
    mid();
    check("rd_c3_done",  RD_DONE, 0);
    check("rd_c3_hold",  RD_DATA, 8'h3C);
    check("rd_c3_busy",  BUSY,    1);
    next_cycle();
    mid();
    check("rd_c4_idle",  BUSY,    0);

`ifdef IOBUF_PARK_DRIVE_EN
    // Parking: write 5A, bus stays driven in IDLE; a later read sees 2 high-Z cycles first.
    next_cycle(); WR_VALID = 1'b1; WR_DATA = 8'h5A;
    mid();
    check("pk_wr_ready", WR_READY, 1);
    next_cycle(); WR_VALID = 1'b0;
    mid();
    check("pk_c1_pad_t", PAD_T, 0);
    check("pk_c1_pad_i", PAD_I, 8'h5A);
    next_cycle();
    mid();
    check("pk_c2_pad_t", PAD_T, 0);
    check("pk_c2_pad_i", PAD_I, 8'h5A);
    check("pk_c2_busy",  BUSY,  0);
    next_cycle(); RD_VALID = 1'b1; PAD_O = 8'hC3;
    mid();
    check("pk_c3_rd_rdy", RD_READY, 1);
    check("pk_c3_pad_t",  PAD_T,    0);
    next_cycle(); RD_VALID = 1'b0;
    mid();
    check("pk_c4_pad_t", PAD_T, 1);
    check("pk_c4_busy",  BUSY,  1);
    next_cycle();
    mid();
    check("pk_c5_pad_t", PAD_T, 1);
    next_cycle();
    mid();
    check("pk_c6_pad_t", PAD_T,   1);
    check("pk_c6_done",  RD_DONE, 0);
    next_cycle();
    mid();
    check("pk_c7_done",  RD_DONE, 1);
    check("pk_c7_data",  RD_DATA, 8'hC3);
`else
    // Single write A5: DRV c1, TURN c2-c3, IDLE c4.
    next_cycle(); WR_VALID = 1'b1; WR_DATA = 8'hA5;
    mid();
    check("sw_wr_ready", WR_READY, 1);
    check("sw_c0_busy",  BUSY,     0);
    next_cycle(); WR_VALID = 1'b0; WR_DATA = '0;
    mid();
    check("sw_c1_pad_t", PAD_T, 0);
    check("sw_c1_pad_i", PAD_I, 8'hA5);
    check("sw_c1_busy",  BUSY,  1);
    next_cycle();
    mid();
    check("sw_c2_pad_t", PAD_T, 1);
    next_cycle();
    mid();
    check("sw_c3_pad_t", PAD_T, 1);
    check("sw_c3_busy",  BUSY,  1);
    next_cycle();
    mid();
    check("sw_c4_busy",  BUSY,  0);
    check("sw_c4_pad_t", PAD_T, 1);

    // Burst 11/22/33: PAD_I 11,22,33 in c1-c3 with PAD_T=0, then two TURN cycles.
    next_cycle(); WR_VALID = 1'b1; WR_DATA = 8'h11;
    mid();
    check("bu_c0_wr_rdy", WR_READY, 1);
    next_cycle(); WR_DATA = 8'h22;
    mid();
    check("bu_c1_wr_rdy", WR_READY, 1);
    check("bu_c1_pad_i",  PAD_I,    8'h11);
    check("bu_c1_pad_t",  PAD_T,    0);
    next_cycle(); WR_DATA = 8'h33;
    mid();
    check("bu_c2_pad_i",  PAD_I,    8'h22);
    check("bu_c2_pad_t",  PAD_T,    0);
    next_cycle(); WR_VALID = 1'b0;
    mid();
    check("bu_c3_pad_i",  PAD_I,    8'h33);
    check("bu_c3_pad_t",  PAD_T,    0);
    next_cycle();
    mid();
    check("bu_c4_pad_t",  PAD_T,    1);
    next_cycle();
    mid();
    check("bu_c5_pad_t",  PAD_T,    1);
    check("bu_c5_busy",   BUSY,     1);
    next_cycle();
    mid();
    check("bu_c6_busy",   BUSY,     0);

    // Asynchronous reset while driving: PAD_T/PAD_I/BUSY drop between clock edges.
    next_cycle(); WR_VALID = 1'b1; WR_DATA = 8'h96;
    mid();
    check("ar_wr_ready", WR_READY, 1);
    next_cycle(); WR_VALID = 1'b0;
    mid();
    check("ar_drv_pad_t", PAD_T, 0);
    #2 RST_N = 1'b0;
    #1;
    check("ar_pad_t", PAD_T, 1);
    check("ar_pad_i", PAD_I, 0);
    check("ar_busy",  BUSY,  0);

    // Contention from reset: W at c0, R at c4, W at c8, R at c12; PAD_T low only in c1/c9.
    WR_VALID = 1'b1; RD_VALID = 1'b1; WR_DATA = 8'h69; PAD_O = 8'h77;
    next_cycle();
    RST_N = 1'b1;
    exp_wr = 13'h0101;
    exp_rd = 13'h1010;
    exp_pt = 13'b1_1101_1111_1101;
    for (int c = 0; c < 13; c++) begin
      mid();
      check($sformatf("ct_c%0d_wr_rdy", c), WR_READY, exp_wr[c]);
      check($sformatf("ct_c%0d_rd_rdy", c), RD_READY, exp_rd[c]);
      check($sformatf("ct_c%0d_pad_t", c),  PAD_T,    exp_pt[c]);
      check($sformatf("ct_c%0d_excl", c),   WR_READY & RD_READY, 0);
      if (c == 1) check("ct_c1_pad_i", PAD_I, 8'h69);
      if (c == 6) begin
        check("ct_c6_done", RD_DONE, 1);
        check("ct_c6_data", RD_DATA, 8'h77);
      end
      next_cycle();
    end
    WR_VALID = 1'b0; RD_VALID = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
